// File: rtl/serial_word_ctrl.sv
`timescale 1ns/1ps
// serial_word_ctrl: sequences an external circular shift register so one DATA_WIDTH word leaves as BEATS beats of PAR bits.
// Latency: the first beat is offered the cycle after the word is accepted; one beat per out handshake.
// Backpressure: in_ready only while idle; out_ready low freezes the register and beat count. Optional replay: SERIAL_WORD_CTRL_REPLAY_EN.
module serial_word_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int PAR        = 1,
    localparam int BEATS     = (DATA_WIDTH + PAR - 1) / PAR,
    localparam int CW        = $clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  csr_load,
    output logic                  csr_enable,
    output logic [DATA_WIDTH-1:0] csr_data_in,
    input  logic [PAR-1:0]        csr_serial_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAR-1:0]        out_data,
    output logic                  out_last,
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
    input  logic                  replay,
`endif
    input  logic                  abort,
    output logic                  busy,
    output logic [CW-1:0]         beat_cnt,
    output logic                  done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          done_q, done_d;
    logic          beat_hs;
    logic          replay_go;

`ifdef SERIAL_WORD_CTRL_REPLAY_EN
    logic word_held_q, word_held_d;

    // A held word may be re-streamed only when no new word competes; the register is back in alignment after a full word.
    always_comb begin
        replay_go = replay & word_held_q & ~in_valid;
    end
`else
    // Without replay support the controller leaves IDLE only for a new word.
    always_comb begin
        replay_go = 1'b0;
    end
`endif

    // Handshake-facing outputs follow the current state and inputs in the same cycle.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == STREAM) & ~abort;
        out_last    = out_valid & (beat_cnt_q == LAST_CNT);
        out_data    = csr_serial_out;
        beat_hs     = out_valid & out_ready;
        csr_enable  = beat_hs;
        csr_load    = (state_q == IDLE) & in_valid & reset_n;
        csr_data_in = in_data;
        busy        = (state_q == STREAM);
        beat_cnt    = beat_cnt_q;
        done        = done_q;
    end

    // Next-state logic: load or replay from IDLE, count beats in STREAM, abort drops the word without a done pulse.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
        word_held_d = word_held_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid || replay_go) begin
                    state_d    = STREAM;
                    beat_cnt_d = '0;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
                    word_held_d = 1'b0;
`endif
                end else if (beat_hs) begin
                    if (out_last) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        done_d     = 1'b1;
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
                        word_held_d = 1'b1;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
            word_held_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
`ifdef SERIAL_WORD_CTRL_REPLAY_EN
            word_held_q <= word_held_d;
`endif
        end
    end

endmodule
